// File: rtl/move_command_transmitter_pkg.sv
// Shared definitions for the rover move-command IR transmitter.
//
// Holds the FSM state codes, the pulse-width protocol unit counts and the
// command field positions. The field positions are also used by the path
// calculator that builds the command word, so both sides agree on layout.
package move_command_transmitter_pkg;

    // State codes are exposed on the debug port, so values are fixed.
    typedef enum logic [3:0] {
        StIdle     = 4'd1,
        StStartOn  = 4'd2,
        StStartOff = 4'd3,
        StBitOn    = 4'd4,
        StBitOff   = 4'd5,
        StGap      = 4'd6
    } tx_state_e;

    // Protocol segment lengths in units.
    localparam int unsigned START_ON_UNITS    = 4;
    localparam int unsigned START_OFF_UNITS   = 1;
    localparam int unsigned BIT_ONE_ON_UNITS  = 2;
    localparam int unsigned BIT_ZERO_ON_UNITS = 1;
    localparam int unsigned BIT_OFF_UNITS     = 1;

    // Command word layout: [11:7] angle, [6:0] distance.
    localparam int unsigned CMD_BITS  = 12;
    localparam int unsigned ANGLE_MSB = 11;
    localparam int unsigned ANGLE_LSB = 7;
    localparam int unsigned DIST_MSB  = 6;
    localparam int unsigned DIST_LSB  = 0;

    // Length of the high burst that encodes one command bit.
    function automatic int unsigned bit_on_units(input logic bit_value);
        return bit_value ? BIT_ONE_ON_UNITS : BIT_ZERO_ON_UNITS;
    endfunction

endpackage

// File: rtl/move_command_transmitter_ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier gated by the frame envelope.
//
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high
//   enable  - registered frame envelope; carrier runs only while high
//   carrier - carrier output, 0 whenever enable is 0
//
// While enable is low the phase counter is held at 0 with the phase at 1, so
// the first cycle of every burst starts at carrier=1 with a fresh half-period.
module ir_carrier_gen #(
    parameter int unsigned CARRIER_HALF = 337
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic carrier
);

    localparam int unsigned CntW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CntW-1:0] half_cnt_q;
    logic            phase_q;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            half_cnt_q <= '0;
            phase_q    <= 1'b1;
        end else if (half_cnt_q == CntW'(CARRIER_HALF - 1)) begin
            half_cnt_q <= '0;
            phase_q    <= ~phase_q;
        end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
        end
    end

    // enable is a register in the parent, so this is a gate of two flops.
    assign carrier = enable & phase_q;

endmodule

// File: rtl/move_command_transmitter.sv
// move_command_transmitter: sends a 12-bit rover move command as a
// pulse-width-coded IR frame on a modulated carrier.
//
// Ports:
//   clock       - system clock
//   reset       - synchronous, active-high
//   send        - start strobe, sampled only in IDLE
//   command     - [11:7] angle, [6:0] distance; latched on acceptance
//   busy        - high from the cycle after acceptance to the end of the last gap
//   done        - one-cycle pulse on the first cycle after the busy window
//   tx_envelope - unmodulated frame envelope
//   tx_out      - envelope AND carrier, drives the IR LED
//   state       - FSM state code for debug
//
// Frame: start burst, start space, then 12 bit bursts each followed by a one-unit
// space, LSB of the command first, then a silent gap. The frame is repeated
// REPEATS times per accepted command.
module move_command_transmitter #(
    parameter int unsigned UNIT_CYCLES  = 16200,
    parameter int unsigned CARRIER_HALF = 337,
    parameter int unsigned REPEATS      = 3,
    parameter int unsigned GAP_UNITS    = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [11:0] command,
    output logic        busy,
    output logic        done,
    output logic        tx_envelope,
    output logic        tx_out,
    output logic [3:0]  state
);

    import move_command_transmitter_pkg::*;

    localparam int unsigned CycW     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned MaxUnits = (GAP_UNITS > START_ON_UNITS) ? GAP_UNITS
                                                                    : START_ON_UNITS;
    localparam int unsigned UnitW    = $clog2(MaxUnits);
    localparam int unsigned RepW     = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    tx_state_e         state_q;
    logic [11:0]       shadow_q;
    logic [3:0]        bit_idx_q;
    logic [RepW-1:0]   rep_q;
    logic [CycW-1:0]   cyc_q;
    logic [UnitW-1:0]  unit_q;

    logic [UnitW-1:0]  last_unit;
    logic              cycle_last;
    logic              carrier;

    // Index of the final unit of the current state.
    always_comb begin
        last_unit = '0;
        case (state_q)
            StStartOn:  last_unit = UnitW'(START_ON_UNITS - 1);
            StStartOff: last_unit = UnitW'(START_OFF_UNITS - 1);
            StBitOn:    last_unit = UnitW'(bit_on_units(shadow_q[bit_idx_q]) - 1);
            StBitOff:   last_unit = UnitW'(BIT_OFF_UNITS - 1);
            StGap:      last_unit = UnitW'(GAP_UNITS - 1);
            default:    last_unit = '0;
        endcase
    end

    assign cycle_last = (cyc_q == CycW'(UNIT_CYCLES - 1));

    // Outputs are assigned together with the state they belong to, so the
    // envelope edges line up exactly with the state boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            bit_idx_q   <= '0;
            rep_q       <= '0;
            cyc_q       <= '0;
            unit_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_envelope <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == StIdle) begin
                cyc_q  <= '0;
                unit_q <= '0;
                if (send) begin
                    shadow_q    <= command;
                    bit_idx_q   <= '0;
                    rep_q       <= '0;
                    state_q     <= StStartOn;
                    busy        <= 1'b1;
                    tx_envelope <= 1'b1;
                end
            end else if (!cycle_last) begin
                cyc_q <= cyc_q + 1'b1;
            end else begin
                cyc_q <= '0;
                if (unit_q != last_unit) begin
                    unit_q <= unit_q + 1'b1;
                end else begin
                    unit_q <= '0;
                    case (state_q)
                        StStartOn: begin
                            state_q     <= StStartOff;
                            tx_envelope <= 1'b0;
                        end
                        StStartOff: begin
                            state_q     <= StBitOn;
                            tx_envelope <= 1'b1;
                        end
                        StBitOn: begin
                            state_q     <= StBitOff;
                            tx_envelope <= 1'b0;
                        end
                        StBitOff: begin
                            if (bit_idx_q == 4'(CMD_BITS - 1)) begin
                                state_q <= StGap;
                            end else begin
                                bit_idx_q   <= bit_idx_q + 1'b1;
                                state_q     <= StBitOn;
                                tx_envelope <= 1'b1;
                            end
                        end
                        StGap: begin
                            if (rep_q != RepW'(REPEATS - 1)) begin
                                rep_q       <= rep_q + 1'b1;
                                bit_idx_q   <= '0;
                                state_q     <= StStartOn;
                                tx_envelope <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clock   (clock),
        .reset   (reset),
        .enable  (tx_envelope),
        .carrier (carrier)
    );

    assign tx_out = tx_envelope & carrier;
    assign state  = state_q;

endmodule

// File: tb/tb_move_command_transmitter.sv
module tb_move_command_transmitter;

    localparam int U = 4;  // UNIT_CYCLES
    localparam int H = 1;  // CARRIER_HALF
    localparam int R = 3;  // REPEATS
    localparam int G = 2;  // GAP_UNITS
    localparam int RUNS_PER_FRAME = 26;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        send = 1'b0;
    logic [11:0] command = '0;
    logic        busy, done, tx_envelope, tx_out;
    logic [3:0]  state;

    always #5 clock = ~clock;

    move_command_transmitter #(
        .UNIT_CYCLES  (U),
        .CARRIER_HALF (H),
        .REPEATS      (R),
        .GAP_UNITS    (G)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .send        (send),
        .command     (command),
        .busy        (busy),
        .done        (done),
        .tx_envelope (tx_envelope),
        .tx_out      (tx_out),
        .state       (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] sb[$];     // commands expected to be transmitted, in order
    int          exp_runs[$];
    int          runs[$];   // observed envelope run lengths, high first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    endtask

    // Reference: envelope as alternating high/low run lengths in cycles.
    function automatic void build_expected(input logic [11:0] c);
        exp_runs.delete();
        for (int r = 0; r < R; r++) begin
            exp_runs.push_back(4 * U);
            exp_runs.push_back(1 * U);
            for (int i = 0; i < 12; i++) begin
                exp_runs.push_back((c[i] ? 2 : 1) * U);
                // the last bit space runs straight into the gap
                exp_runs.push_back((i == 11) ? (1 + G) * U : U);
            end
        end
    endfunction

    // ---------------- monitor ----------------
    logic prev_busy = 1'b0;
    logic run_lvl   = 1'b1;
    int   busy_len = 0, run_len = 0, burst_pos = 0, carrier_bad = 0;
    int   leak = 0, spurious = 0;

    task automatic finish_transmission();
        logic [11:0] c;
        logic [11:0] dec;
        int          first_bad;
        int          n;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: got a completed transmission, expected none");
            return;
        end
        c = sb.pop_front();
        build_expected(c);
        check("busy_cycles", busy_len, R * (5 + 12 + 12 + $countones(c) + G) * U);
        check("run_count", runs.size(), exp_runs.size());
        n = (runs.size() < exp_runs.size()) ? runs.size() : exp_runs.size();
        first_bad = -1;
        for (int i = 0; i < n; i++)
            if (first_bad < 0 && runs[i] != exp_runs[i]) first_bad = i;
        check("run_first_mismatch_index", first_bad, -1);
        for (int f = 0; f < R; f++) begin
            if (runs.size() >= (f + 1) * RUNS_PER_FRAME) begin
                dec = '0;
                for (int i = 0; i < 12; i++)
                    dec[i] = runs[f * RUNS_PER_FRAME + 2 + 2 * i] > U;
                check("frame_decode", dec, c);
            end
        end
        check("carrier_phase_errors", carrier_bad, 0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_busy = 1'b0;
            runs.delete();
        end else begin
            if (!tx_envelope && tx_out) leak++;
            if (busy && !prev_busy) begin
                check("accept_envelope", tx_envelope, 1);
                check("accept_tx_out", tx_out, 1);
                busy_len    = 0;
                run_len     = 0;
                run_lvl     = 1'b1;
                burst_pos   = 0;
                carrier_bad = 0;
                runs.delete();
            end
            if (busy) begin
                busy_len++;
                if (tx_envelope === run_lvl) begin
                    run_len++;
                end else begin
                    runs.push_back(run_len);
                    run_lvl = tx_envelope;
                    run_len = 1;
                end
                if (tx_envelope) begin
                    if (tx_out !== (burst_pos % 2 == 0)) carrier_bad++;
                    burst_pos++;
                end else begin
                    burst_pos = 0;
                end
            end
            if (prev_busy && !busy) begin
                runs.push_back(run_len);
                check("done_after_busy", done, 1);
                finish_transmission();
            end else if (done) begin
                spurious++;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic timeout(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: got no response, expected one within budget", what);
        finish_sim();
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 5000) begin
            @(posedge clock); #1;
            guard++;
        end
        if (busy) timeout("idle");
    endtask

    task automatic send_cmd(input logic [11:0] c);
        wait_idle();
        command = c;
        send    = 1'b1;
        sb.push_back(c);
        @(posedge clock); #1;
        send = 1'b0;
    endtask

    // Random send pulses and command changes while a transmission is running.
    task automatic disturb();
        int guard = 0;
        while (busy && guard < 5000) begin
            command = 12'($urandom);
            send    = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            guard++;
        end
        send = 1'b0;
    endtask

    initial begin
        #1_000_000;
        timeout("global");
    end

    initial begin
        logic [11:0] c1, c2;
        int guard;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_envelope", tx_envelope, 0);
        check("rst_tx_out", tx_out, 0);
        check("rst_state", state, 1);
        reset = 1'b0;
        @(posedge clock); #1;

        send_cmd(12'h000);
        send_cmd(12'hFFF);
        send_cmd(12'h105);
        disturb();

        for (int i = 0; i < 6; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clock);
            #1;
            send_cmd(12'($urandom));
            if ($urandom_range(0, 1) == 1) disturb();
        end

        // send held high: a second transmission starts on the done cycle
        wait_idle();
        c1 = 12'($urandom);
        c2 = 12'($urandom);
        command = c1;
        send    = 1'b1;
        sb.push_back(c1);
        @(posedge clock); #1;
        command = c2;
        guard = 0;
        while (!done && guard < 5000) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!done) timeout("held_done");
        sb.push_back(c2);
        @(posedge clock); #1;
        send = 1'b0;

        // reset in the middle of a frame
        send_cmd(12'($urandom));
        repeat (49) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_envelope", tx_envelope, 0);
        check("midrst_tx_out", tx_out, 0);
        check("midrst_state", state, 1);
        reset = 1'b0;
        void'(sb.pop_back());
        @(posedge clock); #1;

        send_cmd(12'($urandom));

        wait_idle();
        repeat (4) @(posedge clock);
        #1;
        check("spurious_done", spurious, 0);
        check("tx_out_without_envelope", leak, 0);
        check("scoreboard_drained", sb.size(), 0);
        finish_sim();
    end

endmodule
